// File: rtl/ethernet_tx_arbiter.sv
// ethernet_tx_arbiter
//   Frame-granular round-robin arbiter that shares one 64-bit AXI-Stream
//   TX port to the MAC between two sources. A grant covers a whole frame,
//   up to and including the tlast beat. A programmable idle gap follows
//   each frame.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   s0_axis_*               source 0 (protocol reply path) stream in / tready out
//   s1_axis_*               source 1 (user/UDP path) stream in / tready out
//   m_axis_*                stream to the MAC / tready in
//   o_busy                  high while a frame is granted or the gap runs
//   o_frames0, o_frames1    completed-frame counters per source (wrapping)
module ethernet_tx_arbiter #(
  parameter int unsigned IFG_CYCLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,

  input  logic             s0_axis_tvalid,
  input  logic [63:0]      s0_axis_tdata,
  input  logic             s0_axis_tlast,
  input  logic [7:0]       s0_axis_tkeep,
  output logic             s0_axis_tready,

  input  logic             s1_axis_tvalid,
  input  logic [63:0]      s1_axis_tdata,
  input  logic             s1_axis_tlast,
  input  logic [7:0]       s1_axis_tkeep,
  output logic             s1_axis_tready,

  output logic             m_axis_tvalid,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  output logic [7:0]       m_axis_tkeep,
  input  logic             m_axis_tready,

  output logic             o_busy,
  output logic [CNT_W-1:0] o_frames0,
  output logic [CNT_W-1:0] o_frames1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [3:0]       IFG_LD  = IFG_CYCLES[3:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic       last_src, last_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic       inc0, inc1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      last_src  <= 1'b1;
      gap_cnt   <= '0;
      o_frames0 <= '0;
      o_frames1 <= '0;
    end else begin
      state    <= state_nxt;
      last_src <= last_nxt;
      gap_cnt  <= gap_nxt;
      if (inc0) o_frames0 <= o_frames0 + CNT_ONE;
      if (inc1) o_frames1 <= o_frames1 + CNT_ONE;
    end
  end

  // Outputs are decoded from the registered state only, so an asynchronous
  // reset clears them immediately, even mid-frame.
  always_comb begin
    state_nxt      = state;
    last_nxt       = last_src;
    gap_nxt        = gap_cnt;
    inc0           = 1'b0;
    inc1           = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tkeep   = '0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;

    case (state)
      IDLE: begin
        // On a tie, serve the source that did not go last.
        if (s0_axis_tvalid && (!s1_axis_tvalid || last_src))
          state_nxt = GRANT0;
        else if (s1_axis_tvalid)
          state_nxt = GRANT1;
      end

      GRANT0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tkeep   = s0_axis_tkeep;
        s0_axis_tready = m_axis_tready;
        if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
          inc0      = 1'b1;
          last_nxt  = 1'b0;
          gap_nxt   = IFG_LD;
          state_nxt = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end

      GRANT1: begin
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tkeep   = s1_axis_tkeep;
        s1_axis_tready = m_axis_tready;
        if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
          inc1      = 1'b1;
          last_nxt  = 1'b1;
          gap_nxt   = IFG_LD;
          state_nxt = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end

      GAP: begin
        gap_nxt = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1)
          state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule
